// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_HOLD,
        SEL_ERET,
        SEL_REDIR,
        SEL_RET,
        SEL_SEQ
    } next_sel_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// Request and status bundle between the fetch control logic and the PC unit.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             exc_valid;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] epc;
    logic             ras_empty;
    logic             ras_full;
    logic             misalign_err;
    logic             ras_underflow;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret, exc_valid, eret,
        input  pc, pc_plus, epc, ras_empty, ras_full, misalign_err, ras_underflow
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret, exc_valid, eret,
        output pc, pc_plus, epc, ras_empty, ras_full, misalign_err, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop replaces the top entry,
// and a push onto a full stack silently overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    // ptr names the next free slot, so the live top sits one below it
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            if (do_pop) begin
                mem[top_idx] <= push_data;
            end else begin
                mem[ptr] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop && !push) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC select, exception PC,
// return-address stack and alignment checking of redirect targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] next_pc;
    logic             misalign_q;
    logic             underflow_q;
    logic             misalign_d;
    logic             underflow_d;
    logic             active;
    logic             ret_req;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_empty;
    logic             ras_full;
    next_sel_t        sel;

    assign pc_plus = pc_q + STEP;

    // Exceptions and stalls swallow every other request; eret also cancels ret
    assign active      = !bus.exc_valid && !bus.stall;
    assign ret_req     = active && bus.ret && !bus.eret;
    assign ras_push    = active && bus.call;
    assign ras_pop     = ret_req && !ras_empty;
    assign underflow_d = ret_req && ras_empty;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (bus.exc_valid) begin
            sel = SEL_EXC;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.eret) begin
            sel = SEL_ERET;
        end else if (bus.redirect_valid) begin
            sel = SEL_REDIR;
        end else if (ras_pop) begin
            sel = SEL_RET;
        end
    end

    // Computed targets are forced onto an instruction boundary and flagged if they were not
    always_comb begin
        next_pc    = pc_plus;
        raw_target = '0;
        misalign_d = 1'b0;
        case (sel)
            SEL_EXC:   next_pc = EXC_VECTOR;
            SEL_HOLD:  next_pc = pc_q;
            SEL_ERET:  next_pc = epc_q;
            SEL_REDIR: raw_target = bus.redirect_target;
            SEL_RET:   raw_target = ras_top;
            default:   next_pc = pc_plus;
        endcase
        if (sel == SEL_REDIR || sel == SEL_RET) begin
            next_pc    = raw_target & ~LOW_MASK;
            misalign_d = |(raw_target & LOW_MASK);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= next_pc;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
            if (bus.exc_valid) begin
                epc_q <= pc_q;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_plus;
    assign bus.epc           = epc_q;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.misalign_err  = misalign_q;
    assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based reference model.
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] EXC   = 32'h0000_0080;

    logic clk;
    logic reset;
    logic reset8;
    int   checks;
    int   errors;
    bit   check_en;

    pc_unit_if #(.WIDTH(32)) bus ();
    pc_unit_if #(.WIDTH(8))  bus8 ();

    pc_unit #(
        .WIDTH        (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0),
        .EXC_VECTOR   (EXC),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_unit #(
        .WIDTH        (8),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (8'h0),
        .EXC_VECTOR   (8'h80),
        .RAS_DEPTH    (DEPTH)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requests from a negedge and return at the following negedge
    task automatic applyStimulus(input bit stl, input bit exc, input bit er, input bit rv,
                                 input logic [31:0] tgt, input bit cl, input bit rt);
        bus.stall           = stl;
        bus.exc_valid       = exc;
        bus.eret            = er;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.call            = cl;
        bus.ret             = rt;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    // Reference model: PC, EPC and a bounded queue as the return stack (newest at back)
    logic [31:0] m_pc, m_epc, m_nxt, m_ret_addr, m_tgt;
    logic [31:0] m_ras[$];
    bit          m_have_ret, m_mis, m_und;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            m_mis = 0;
            m_und = 0;
            m_ras.delete();
        end else begin
            m_nxt      = m_pc + 32'd4;
            m_mis      = 0;
            m_und      = 0;
            m_have_ret = 0;
            m_tgt      = bus.redirect_target;
            if (bus.exc_valid) begin
                m_epc = m_pc;
                m_nxt = EXC;
            end else if (bus.stall) begin
                m_nxt = m_pc;
            end else begin
                if (bus.ret && !bus.eret) begin
                    if (m_ras.size() == 0) begin
                        m_und = 1;
                    end else begin
                        m_ret_addr = m_ras.pop_back();
                        m_have_ret = 1;
                    end
                end
                if (bus.call) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(m_pc + 32'd4);
                end
                if (bus.eret) begin
                    m_nxt = m_epc;
                end else if (bus.redirect_valid) begin
                    m_nxt = {m_tgt[31:2], 2'b00};
                    m_mis = (m_tgt[1:0] != 2'b00);
                end else if (m_have_ret) begin
                    m_nxt = {m_ret_addr[31:2], 2'b00};
                    m_mis = (m_ret_addr[1:0] != 2'b00);
                end
            end
            m_pc = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) begin
            checkOutput("pc",            bus.pc,            m_pc);
            checkOutput("pc_plus",       bus.pc_plus,       m_pc + 32'd4);
            checkOutput("epc",           bus.epc,           m_epc);
            checkOutput("ras_empty",     32'(bus.ras_empty),     32'(m_ras.size() == 0));
            checkOutput("ras_full",      32'(bus.ras_full),      32'(m_ras.size() == DEPTH));
            checkOutput("misalign_err",  32'(bus.misalign_err),  32'(m_mis));
            checkOutput("ras_underflow", 32'(bus.ras_underflow), 32'(m_und));
        end
    end

    initial begin
        bus8.stall           = 1'b0;
        bus8.exc_valid       = 1'b0;
        bus8.eret            = 1'b0;
        bus8.redirect_valid  = 1'b0;
        bus8.redirect_target = 8'h0;
        bus8.call            = 1'b0;
        bus8.ret             = 1'b0;
        reset8 = 1'b1;
        repeat (2) @(negedge clk);
        reset8 = 1'b0;
        repeat (63) @(negedge clk);
        checkOutput("w8_pc_fc",   32'(bus8.pc),      32'h0000_00FC);
        checkOutput("w8_plus_fc", 32'(bus8.pc_plus), 32'h0000_0000);
        @(negedge clk);
        checkOutput("w8_pc_wrap", 32'(bus8.pc),      32'h0000_0000);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        check_en = 0;
        reset    = 1'b1;
        bus.stall = 0; bus.exc_valid = 0; bus.eret = 0; bus.redirect_valid = 0;
        bus.redirect_target = 32'h0; bus.call = 0; bus.ret = 0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        check_en = 1;

        checkOutput("rst_pc",        bus.pc,             32'h0);
        checkOutput("rst_epc",       bus.epc,            32'h0);
        checkOutput("rst_empty",     32'(bus.ras_empty), 32'h1);
        checkOutput("rst_full",      32'(bus.ras_full),  32'h0);
        idle(); checkOutput("seq_4",  bus.pc, 32'h4);
        idle(); checkOutput("seq_8",  bus.pc, 32'h8);
        idle(); checkOutput("seq_c",  bus.pc, 32'hC);
        checkOutput("seq_empty", 32'(bus.ras_empty), 32'h1);

        applyStimulus(0, 0, 0, 1, 32'h10, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h100, 1, 0);
        checkOutput("call_redir_pc",    bus.pc,             32'h100);
        checkOutput("call_redir_empty", 32'(bus.ras_empty), 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("ret_pc",    bus.pc,             32'h14);
        checkOutput("ret_empty", 32'(bus.ras_empty), 32'h1);

        applyStimulus(0, 0, 0, 1, 32'h0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
        checkOutput("five_call_full", 32'(bus.ras_full), 32'h1);
        checkOutput("five_call_pc",   bus.pc,            32'h14);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1); checkOutput("ret1", bus.pc, 32'h14);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1); checkOutput("ret2", bus.pc, 32'h10);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1); checkOutput("ret3", bus.pc, 32'hC);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1); checkOutput("ret4", bus.pc, 32'h8);
        checkOutput("ret4_empty", 32'(bus.ras_empty), 32'h1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("ret5_pc",  bus.pc,                 32'hC);
        checkOutput("ret5_und", 32'(bus.ras_underflow), 32'h1);
        idle();
        checkOutput("und_clear", 32'(bus.ras_underflow), 32'h0);

        applyStimulus(0, 0, 0, 1, 32'h40, 0, 0);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("exc_pc",  bus.pc,  32'h80);
        checkOutput("exc_epc", bus.epc, 32'h40);
        idle();
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 0);
        checkOutput("eret_pc", bus.pc, 32'h40);
        applyStimulus(1, 0, 0, 1, 32'h300, 0, 0);
        checkOutput("stall_hold", bus.pc, 32'h40);
        idle();
        checkOutput("stall_drop", bus.pc, 32'h44);

        applyStimulus(0, 0, 0, 1, 32'h203, 0, 0);
        checkOutput("mis_pc",   bus.pc,                32'h200);
        checkOutput("mis_high", 32'(bus.misalign_err), 32'h1);
        idle();
        checkOutput("mis_low",  32'(bus.misalign_err), 32'h0);

        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        checkOutput("wrap_plus", bus.pc_plus, 32'h0);
        idle();
        checkOutput("wrap_pc", bus.pc, 32'h0);

        repeat (3) applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
        bus.call = 0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_pc",    bus.pc,             32'h0);
        checkOutput("async_epc",   bus.epc,            32'h0);
        checkOutput("async_empty", 32'(bus.ras_empty), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, tgt,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
